// File: rtl/rv32i_types.sv
// rv32i_types: shared opcode and state encodings for the iterative multiply unit
package rv32i_types;
    typedef enum logic [2:0] {MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011} mult_op_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
endpackage

// File: rtl/mult_sign_fix.sv
// mult_sign_fix: operand magnitude/sign extraction at issue and signed result fix-up at completion
module mult_sign_fix
    import rv32i_types::*;
(
    input  logic [2:0]  op_in,
    input  logic [31:0] rs1_v,
    input  logic [31:0] rs2_v,
    output logic [31:0] mag1,
    output logic [31:0] mag2,
    output logic        neg,
    input  mult_op_t    op_q,
    input  logic        neg_q,
    input  logic [63:0] prod,
    output logic [31:0] result
);
    logic        s1, s2;
    logic [63:0] fixed;
    always_comb begin
        s1 = (op_in != MULHU) && rs1_v[31];
        s2 = (op_in == MUL || op_in == MULH) && rs2_v[31];
        mag1 = s1 ? -rs1_v : rs1_v;
        mag2 = s2 ? -rs2_v : rs2_v;
        neg = s1 ^ s2;
        fixed = neg_q ? -prod : prod;
        result = (op_q == MUL) ? fixed[31:0] : fixed[63:32];
    end
endmodule

// File: rtl/fu_mult_iter.sv
// fu_mult_iter: iterative radix-2^K RV32M multiplier holding a tagged result for the CDB
module fu_mult_iter
    import rv32i_types::*;
#(
    parameter int BITS_PER_CYCLE = 2,
    parameter int ROB_ID_W       = 8,
    parameter int PHYS_W         = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          funct3,
    input  logic [31:0]         rs1_v,
    input  logic [31:0]         rs2_v,
    input  logic [ROB_ID_W-1:0] rob_id,
    input  logic [PHYS_W-1:0]   rd_phys,
    input  logic                flush,
    output logic                mult_free,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_value,
    output logic [ROB_ID_W-1:0] out_rob_id,
    output logic [PHYS_W-1:0]   out_rd_phys
);
    localparam int ITER = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITER + 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER);
    mult_state_t         state, state_n;
    mult_op_t            op_q;
    logic [CNT_W-1:0]    cnt;
    logic [63:0]         acc, mcand;
    logic [31:0]         mplier, mag1, mag2, result;
    logic                neg, neg_q;
    logic [ROB_ID_W-1:0] rob_q;
    logic [PHYS_W-1:0]   rd_q;
    mult_sign_fix u_fix (
        .op_in (funct3),
        .rs1_v (rs1_v),
        .rs2_v (rs2_v),
        .mag1  (mag1),
        .mag2  (mag2),
        .neg   (neg),
        .op_q  (op_q),
        .neg_q (neg_q),
        .prod  (acc),
        .result(result)
    );
    // CALC spends one extra cycle at cnt==LAST so the finished accumulator is registered before the fix-up
    always_comb begin
        state_n = state;
        mult_free = (state == IDLE);
        out_valid = (state == DONE);
        if (flush) state_n = IDLE;
        else if (state == IDLE && start) state_n = CALC;
        else if (state == CALC && cnt == LAST) state_n = DONE;
        else if (state == DONE && out_ready) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q <= MUL;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            neg_q <= 1'b0;
            rob_q <= '0;
            rd_q <= '0;
            out_value <= '0;
            out_rob_id <= '0;
            out_rd_phys <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == CALC) begin
                op_q <= mult_op_t'(funct3);
                cnt <= '0;
                acc <= '0;
                mcand <= {32'd0, mag1};
                mplier <= mag2;
                neg_q <= neg;
                rob_q <= rob_id;
                rd_q <= rd_phys;
            end else if (state == CALC) begin
                acc <= acc + mcand * 64'(mplier[BITS_PER_CYCLE-1:0]);
                mcand <= mcand << BITS_PER_CYCLE;
                mplier <= mplier >> BITS_PER_CYCLE;
                cnt <= cnt + 1'b1;
                if (state_n == DONE) begin
                    out_value <= result;
                    out_rob_id <= rob_q;
                    out_rd_phys <= rd_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_fu_mult_iter.sv
// tb_fu_mult_iter: directed self-checking bench for the iterative multiplier
module tb_fu_mult_iter;
    logic        clk = 1'b0;
    logic        rst, start, flush, out_ready, mult_free, out_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1_v, rs2_v, out_value;
    logic [7:0]  rob_id, out_rob_id;
    logic [5:0]  rd_phys, out_rd_phys;
    int checks = 0;
    int errors = 0;

    fu_mult_iter dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1_v(rs1_v), .rs2_v(rs2_v),
        .rob_id(rob_id), .rd_phys(rd_phys), .flush(flush), .mult_free(mult_free),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_rob_id(out_rob_id), .out_rd_phys(out_rd_phys)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] rob, input logic [5:0] rd, output int lat, output logic busy_ok);
        start = 1'b1; funct3 = f; rs1_v = a; rs2_v = b; rob_id = rob; rd_phys = rd;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (mult_free !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({mult_free, out_valid} !== 2'b10 || out_value !== 0 || out_rob_id !== 0 || out_rd_phys !== 0) begin
            errors++;
            $display("FAIL reset: free=%b valid=%b value=%h rob=%h rd=%h, required 1 0 0 0 0",
                     mult_free, out_valid, out_value, out_rob_id, out_rd_phys);
        end
    endtask

    task automatic test_basic;
        int lat;
        logic ok;
        out_ready = 1'b1;
        issue(3'b000, 32'd7, 32'd6, 8'hA5, 6'd33, lat, ok);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL latency: %0d, required 17", lat); end
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL busy: mult_free high during op, required low"); end
        checks++;
        if (out_value !== 32'd42) begin errors++; $display("FAIL mul7x6: %h, required 0000002a", out_value); end
        checks++;
        if (out_rob_id !== 8'hA5 || out_rd_phys !== 6'd33) begin
            errors++;
            $display("FAIL tags: rob=%h rd=%0d, required a5 33", out_rob_id, out_rd_phys);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || mult_free !== 1'b1) begin
            errors++;
            $display("FAIL handshake: valid=%b free=%b, required 0 1", out_valid, mult_free);
        end
    endtask

    task automatic test_ops;
        logic [2:0]  ops [7] = '{3'b001, 3'b001, 3'b000, 3'b011, 3'b010, 3'b001, 3'b000};
        logic [31:0] as  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] bs  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd6, 32'd6};
        logic [31:0] ex  [7] = '{32'h40000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFD6};
        int lat;
        logic ok;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], 8'(i), 6'(i), lat, ok);
            checks++;
            if (out_value !== ex[i]) begin
                errors++;
                $display("FAIL op%0d f=%b %h*%h: %h, required %h", i, ops[i], as[i], bs[i], out_value, ex[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic ok;
        logic stable = 1'b1;
        out_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd4, 8'h11, 6'd5, lat, ok);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1);
            rs1_v = 32'd100; rs2_v = 32'd100; rob_id = 8'h22;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || mult_free !== 1'b0 || out_value !== 32'd12 || out_rob_id !== 8'h11) stable = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL hold: valid=%b free=%b value=%h rob=%h, required 1 0 0000000c 11",
                     out_valid, mult_free, out_value, out_rob_id);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mult_free !== 1'b1) begin
            errors++;
            $display("FAIL release: valid=%b free=%b, required 0 1", out_valid, mult_free);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mult_free !== 1'b1) begin errors++; $display("FAIL ignored_start: free=%b, required 1", mult_free); end
    endtask

    task automatic test_flush;
        int lat;
        logic ok;
        logic quiet = 1'b1;
        out_ready = 1'b1;
        start = 1'b1; funct3 = 3'b000; rs1_v = 32'd9; rs2_v = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mult_free !== 1'b1) begin
            errors++;
            $display("FAIL flush_calc: valid=%b free=%b, required 0 1", out_valid, mult_free);
        end
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin errors++; $display("FAIL flush_emit: result appeared, required none"); end
        out_ready = 1'b0;
        issue(3'b000, 32'd9, 32'd9, 8'h01, 6'd1, lat, ok);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mult_free !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: valid=%b free=%b, required 0 1", out_valid, mult_free);
        end
        issue(3'b000, 32'd3, 32'd5, 8'h3C, 6'd7, lat, ok);
        checks++;
        if (out_value !== 32'd15 || lat !== 17) begin
            errors++;
            $display("FAIL post_flush: value=%h lat=%0d, required 0000000f 17", out_value, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        int lat;
        logic ok;
        out_ready = 1'b1;
        start = 1'b1; funct3 = 3'b001; rs1_v = 32'd5; rs2_v = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mult_free !== 1'b1 || out_value !== 0) begin
            errors++;
            $display("FAIL async_rst: valid=%b free=%b value=%h, required 0 1 0", out_valid, mult_free, out_value);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(3'b011, 32'd2, 32'd3, 8'h77, 6'd9, lat, ok);
        checks++;
        if (out_value !== 32'd0 || out_rob_id !== 8'h77 || lat !== 17) begin
            errors++;
            $display("FAIL after_rst: value=%h rob=%h lat=%0d, required 0 77 17", out_value, out_rob_id, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; out_ready = 1'b0;
        funct3 = 3'b000; rs1_v = '0; rs2_v = '0; rob_id = '0; rd_phys = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_ops();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fu_mult_iter.md
Name: fu_mult_iter

Overview:
- Iterative RV32M multiply functional unit, directly downstream of the reservation station.
- Accepts one issued multiply per `start` pulse and computes it over several cycles with a radix-2^K shift-add datapath.
- Holds the tagged result until the CDB accepts it.
- Drives the `mult_status` "free" signal back to the reservation station, which issues a multiply only while it is high.

Parameters:
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration; must be 1, 2, 4 or 8.
- ROB_ID_W, 8, width of the ROB tag.
- PHYS_W, 6, width of the physical destination register index.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  issue pulse from the reservation station.
- funct3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- rs1_v  in  32  operand 1, read from the physical register file.
- rs2_v  in  32  operand 2.
- rob_id  in  ROB_ID_W  ROB tag of the issued instruction.
- rd_phys  in  PHYS_W  physical destination register.
- flush  in  1  synchronous kill of any in-flight or held operation.
- mult_free  out  1  high only in IDLE; the reservation station issues only while this is high.
- out_valid  out  1  result available for the CDB.
- out_ready  in  1  CDB grant.
- out_value  out  32  result value.
- out_rob_id  out  ROB_ID_W  tag of the result.
- out_rd_phys  out  PHYS_W  destination register of the result.

Behaviour:
- Reset: asynchronous, active-high.
  - state=IDLE, iteration counter=0, accumulator=0.
  - mult_free=1, out_valid=0.
  - out_value, out_rob_id and out_rd_phys all 0.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on `start && !flush`. At that edge the block latches:
  - funct3, rob_id, rd_phys;
  - |rs1| and |rs2| as 32-bit unsigned magnitudes (an operand is negative only if treated as signed by funct3 and its bit31=1);
  - neg = sign1 XOR sign2;
  - accumulator=0, counter=0.
- Signedness by funct3:
  - MUL, MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
  - MUL low word is identical under either signedness.
  - 0x80000000 has magnitude 2^31, which fits unsigned.
- CALC, each cycle:
  - accumulator += multiplicand × (low BITS_PER_CYCLE bits of multiplier), shifted into position.
  - The multiplier shifts right by BITS_PER_CYCLE.
  - counter increments.
  - After ITER = 32/BITS_PER_CYCLE cycles, state -> DONE.
- DONE entry: the 64-bit product is two's-complement negated if neg. The output registers are loaded with:
  - out_value = product[31:0] for MUL, otherwise product[63:32];
  - out_rob_id and out_rd_phys from the latched tags.
- Latency: `start` sampled at edge 0 gives out_valid=1 after edge ITER+1 (17 cycles at the default).
- DONE: out_valid=1 and all outputs stable until `out_ready`. At the edge with `out_valid && out_ready`, state -> IDLE and out_valid=0.
- `start` while not in IDLE: ignored. No state change and no error.
- `flush`, any state: next state=IDLE, out_valid=0, latched operation discarded. Flush wins over a simultaneous `start` or `out_ready`.
- Back-to-back issue: mult_free returns high the cycle after the handshake, so the next `start` is accepted one cycle later. No same-cycle re-issue.
- Reset mid-CALC or mid-DONE: immediate abandon and all reset values restored; the result is never emitted.
- mult_free is combinational from state only; it has no path from `start`.

Decomposition:
- rv32i_types package gains:
  - enum mult_op_t {MUL=3'b000, MULH=3'b001, MULHSU=3'b010, MULHU=3'b011};
  - enum mult_state_t {IDLE, CALC, DONE}.
- The fu_input_t and fu_output_t wrappers at the integration level map their fields onto the flat ports above.
- One natural sub-module, `mult_sign_fix`, is purely combinational:
  - operand magnitude and sign extraction from funct3;
  - final conditional 64-bit negation and upper/lower word select.
- The FSM, counter and accumulator stay in fu_mult_iter.

Test Plan:
- MUL rs1=7, rs2=6, out_ready=1 -> out_valid rises exactly 17 cycles after start; out_value=42; out_rob_id and out_rd_phys echo the inputs; mult_free low throughout.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; MUL of the same operands -> 0x00000001.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- Back-pressure: out_ready held 0 for 5 cycles after out_valid -> outputs unchanged, mult_free=0, a second `start` ignored. Raising out_ready -> one handshake, then mult_free=1 next cycle.
- Flush at CALC cycle 8, and separately in DONE with out_ready=1 -> no result emitted; IDLE next cycle. A new MUL 3×5 then yields 15.
- rst asserted asynchronously mid-CALC (between clock edges) -> out_valid=0 and mult_free=1 immediately. After release, MULHU 2×3 -> 0.
